executs_mdu: RTL and testbench

EXECUTS_MDU -- requirements
Module: executs_mdu

---
 rtl/minisys_pkg.sv | 27 ++
 rtl/executs_mdu_if.sv | 25 ++
 rtl/executs_mdu_iter_core.sv | 73 +++++++
 rtl/executs_mdu.sv | 142 ++++++++++++++
 tb/tb_executs_mdu.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/minisys_pkg.sv
// Shared minisys definitions: R-format function codes for the HI/LO unit and
// the multiply/divide FSM state encoding.
package minisys_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mdu_code(input logic [5:0] fn);
    return (fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) ||
           (fn == FN_MTLO) || (fn == FN_MULT) || (fn == FN_MULTU) ||
           (fn == FN_DIV)  || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/executs_mdu_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface executs_mdu_if #(parameter int WIDTH = 32);
  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // start while busy is dropped (stall flags it), done pulses when HI/LO are new.
  logic             start;
  logic [5:0]       Function_opcode;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output start, Function_opcode, Read_data_1, Read_data_2,
    input  busy, done, stall, HI, LO, mf_data
  );

  modport slave (
    input  start, Function_opcode, Read_data_1, Read_data_2,
    output busy, done, stall, HI, LO, mf_data
  );
endinterface

// File: rtl/executs_mdu_iter_core.sv
// One-bit-per-cycle datapath on unsigned magnitudes: shift-add multiply or
// restoring divide. acc_hi/acc_lo end as {product} or {remainder, quotient}.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] opb;
  logic [CNT_W-1:0] cnt;
  logic             div_mode;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_part;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_part = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_part - {1'b0, opb};
    hi_next  = '0;
    lo_next  = '0;
    if (div_mode) begin
      // A borrow out of the trial subtract means the divisor did not fit: restore.
      if (!div_diff[WIDTH]) begin
        hi_next = div_diff[WIDTH-1:0];
        lo_next = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_part[WIDTH-1:0];
        lo_next = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc_hi   <= '0;
      acc_lo   <= op_a;
      opb      <= op_b;
      cnt      <= '0;
      div_mode <= is_div;
    end else if (step) begin
      acc_hi   <= hi_next;
      acc_lo   <= lo_next;
      cnt      <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/executs_mdu.sv
// HI/LO multiply/divide unit: decode, sign handling, control FSM and the
// architectural HI/LO registers around the iterative core.
module executs_mdu
  import minisys_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  executs_mdu_if.slave bus,
  output mdu_state_e   dbg_state
);

  mdu_state_e state, state_next;

  logic [5:0]       fn;
  logic [WIDTH-1:0] rs, rt;
  logic             op_mul, op_div, op_signed;
  logic             rs_neg, rt_neg, div_zero;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             accept, start_iter;
  logic             busy, done, step, core_last;

  logic             neg_q_r, neg_r_r, is_div_r;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic [WIDTH-1:0] hi_r, lo_r;

  assign fn        = bus.Function_opcode;
  assign rs        = bus.Read_data_1;
  assign rt        = bus.Read_data_2;
  assign op_mul    = (fn == FN_MULT) || (fn == FN_MULTU);
  assign op_div    = (fn == FN_DIV)  || (fn == FN_DIVU);
  assign op_signed = (fn == FN_MULT) || (fn == FN_DIV);
  assign rs_neg    = op_signed && rs[WIDTH-1];
  assign rt_neg    = op_signed && rt[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs : rs;
  assign rt_mag    = rt_neg ? -rt : rt;
  assign div_zero  = op_div && (rt == '0);

  assign accept     = bus.start && !busy;
  assign start_iter = accept && (op_mul || op_div) && !div_zero;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; IDLE and DONE both accept, so they share one decision.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept && div_zero)  state_next = ST_DONE;
        else if (start_iter)     state_next = ST_CALC;
        else                     state_next = ST_IDLE;
      end
      ST_CALC: if (core_last) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    step = 1'b0;
    case (state)
      ST_CALC: begin busy = 1'b1; step = 1'b1; end
      ST_FIX:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clock),
    .rst_n  (reset_n),
    .load   (start_iter),
    .step   (step),
    .is_div (op_div),
    .op_a   (rs_mag),
    .op_b   (rt_mag),
    .acc_hi (core_hi),
    .acc_lo (core_lo),
    .last   (core_last)
  );

  // Result signs are captured with the operands so later input changes are harmless.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      is_div_r <= 1'b0;
    end else if (start_iter) begin
      neg_q_r  <= rs_neg ^ rt_neg;
      neg_r_r  <= rs_neg;
      is_div_r <= op_div;
    end
  end

  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = neg_q_r ? -prod : prod;
    if (is_div_r) begin
      hi_fix = neg_r_r ? -core_hi : core_hi;
      lo_fix = neg_q_r ? -core_lo : core_lo;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state == ST_FIX) begin
      hi_r <= hi_fix;
      lo_r <= lo_fix;
    end else if (accept) begin
      if (fn == FN_MTHI) hi_r <= rs;
      if (fn == FN_MTLO) lo_r <= rs;
      if (div_zero) begin
        hi_r <= rs;
        lo_r <= '1;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.stall   = bus.start && busy && is_mdu_code(fn);
  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;
  assign bus.mf_data = (fn == FN_MFHI) ? hi_r : lo_r;
  assign dbg_state   = state;

endmodule

// File: tb/tb_executs_mdu.sv
// Bench for executs_mdu at WIDTH=32: fixed vectors, hand sequences for stall,
// back-to-back and mid-operation reset, and random ops against an arithmetic model.
module tb_executs_mdu;
  import minisys_pkg::*;

  localparam int W = 32;

  logic       clock;
  logic       reset_n;
  mdu_state_e dbg_state;

  executs_mdu_if #(.WIDTH(W)) bus ();

  executs_mdu #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic logic [2*W-1:0] ref_model(input logic [5:0] fn,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ref_model = '0;
    case (fn)
      FN_MULT:  begin q = sa * sb; ref_model = q; end
      FN_MULTU: begin p = ua * ub; ref_model = p; end
      FN_DIV, FN_DIVU: begin
        if (b == '0) ref_model = {a, {W{1'b1}}};
        else if (fn == FN_DIVU) begin
          p = ua / ub;
          ua = ua % ub;
          ref_model = {ua[W-1:0], p[W-1:0]};
        end else begin
          q = sa / sb;
          r = sa % sb;
          ref_model = {r[W-1:0], q[W-1:0]};
        end
      end
      default: ref_model = '0;
    endcase
  endfunction

  // driver: issue at a negedge, return at the negedge where done is seen
  task automatic do_op(input logic [5:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] exp,
                       input int exp_lat);
    int n;
    logic [2*W-1:0] e;
    exp_q.push_back(exp);
    bus.start = 1'b1;
    bus.Function_opcode = fn;
    bus.Read_data_1 = a;
    bus.Read_data_2 = b;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    bus.Function_opcode = 6'h00;
    bus.Read_data_1 = $urandom();
    bus.Read_data_2 = $urandom();
    n = 1;
    while (!bus.done && n < 100) begin
      @(negedge clock);
      n++;
    end
    e = exp_q.pop_front();
    check("latency", 64'(n), 64'(exp_lat));
    check("hi", 64'(bus.HI), 64'(e[2*W-1:W]));
    check("lo", 64'(bus.LO), 64'(e[W-1:0]));
  endtask

  task automatic do_mt(input logic [5:0] fn, input logic [W-1:0] a);
    bus.start = 1'b1;
    bus.Function_opcode = fn;
    bus.Read_data_1 = a;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    bus.Function_opcode = 6'h00;
    check("mt_busy", 64'(bus.busy), 64'd0);
    check("mt_done", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [5:0]   fn;
    logic [W-1:0] a, b;
    int           n, pulses;
    logic [5:0]   ops[4];

    ops[0] = FN_MULT; ops[1] = FN_MULTU; ops[2] = FN_DIV; ops[3] = FN_DIVU;

    tbl[0] = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
    tbl[1] = '{FN_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 34};
    tbl[2] = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    tbl[3] = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    tbl[4] = '{FN_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1};
    tbl[5] = '{FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34};
    tbl[6] = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
    tbl[7] = '{FN_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 34};
    tbl[8] = '{FN_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1};

    bus.start = 1'b0;
    bus.Function_opcode = 6'h00;
    bus.Read_data_1 = '0;
    bus.Read_data_2 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // MTHI / MTLO
    do_mt(FN_MTHI, 32'h0000ABCD);
    check("mthi", 64'(bus.HI), 64'h0000ABCD);
    do_mt(FN_MTLO, 32'h12340000);
    check("mtlo", 64'(bus.LO), 64'h12340000);
    check("mtlo_keep_hi", 64'(bus.HI), 64'h0000ABCD);

    // fixed vectors
    for (int i = 0; i < 9; i++)
      do_op(tbl[i].fn, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, tbl[i].lat);

    // MULT then MFLO / MFHI read path; MFLO with start has no effect
    do_op(FN_MULT, 32'hFFFFFFFD, 32'h00000005, {32'hFFFFFFFF, 32'hFFFFFFF1}, 34);
    @(negedge clock);
    bus.Function_opcode = FN_MFLO;
    #1 check("mflo", 64'(bus.mf_data), 64'hFFFFFFF1);
    bus.Function_opcode = FN_MFHI;
    #1 check("mfhi", 64'(bus.mf_data), 64'hFFFFFFFF);
    bus.start = 1'b1;
    bus.Function_opcode = FN_MFLO;
    bus.Read_data_1 = 32'h5A5A5A5A;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    check("mf_busy", 64'(bus.busy), 64'd0);
    check("mf_keep_lo", 64'(bus.LO), 64'hFFFFFFF1);

    // stall: MTHI while MULTU busy is dropped
    do_mt(FN_MTHI, 32'h0F0F0F0F);
    bus.start = 1'b1;
    bus.Function_opcode = FN_MULTU;
    bus.Read_data_1 = 32'hFFFFFFFF;
    bus.Read_data_2 = 32'h00000002;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    n = 1;
    while (n < 5) begin @(negedge clock); n++; end
    bus.start = 1'b1;
    bus.Function_opcode = FN_MTHI;
    bus.Read_data_1 = 32'hDEADBEEF;
    #1 check("stall", 64'(bus.stall), 64'd1);
    @(posedge clock);
    @(negedge clock);
    n++;
    bus.start = 1'b0;
    bus.Function_opcode = 6'h00;
    check("stall_busy", 64'(bus.busy), 64'd1);
    check("stall_hi_kept", 64'(bus.HI), 64'h0F0F0F0F);
    while (!bus.done && n < 100) begin @(negedge clock); n++; end
    check("stall_latency", 64'(n), 64'd34);
    check("stall_hi", 64'(bus.HI), 64'h00000001);
    check("stall_lo", 64'(bus.LO), 64'hFFFFFFFE);
    // back-to-back: issued in the DONE cycle
    do_op(FN_MULTU, 32'd3, 32'd7, {32'd0, 32'd21}, 34);

    // randomized ops, all back-to-back
    for (int i = 0; i < 30; i++) begin
      fn = ops[$urandom_range(0, 3)];
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        default: b = $urandom();
      endcase
      if ((fn == FN_DIV || fn == FN_DIVU) && b == '0)
        do_op(fn, a, b, ref_model(fn, a, b), 1);
      else
        do_op(fn, a, b, ref_model(fn, a, b), 34);
    end

    // reset in the middle of a DIVU
    @(negedge clock);
    do_mt(FN_MTHI, 32'h55AA55AA);
    do_mt(FN_MTLO, 32'hA5A5A5A5);
    bus.start = 1'b1;
    bus.Function_opcode = FN_DIVU;
    bus.Read_data_1 = 32'h12345678;
    bus.Read_data_2 = 32'h00000003;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hi", 64'(bus.HI), 64'd0);
    check("mid_rst_lo", 64'(bus.LO), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.done) pulses++;
    end
    check("no_done_after_rst", 64'(pulses), 64'd0);
    do_op(FN_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
